// File: rtl/graycode_pkg.sv
// rtl/graycode_pkg.sv - shared constants and arbiter state type for the gray-code counter slice
package graycode_pkg;

  localparam int BTN_UP       = 0;
  localparam int BTN_DOWN     = 1;
  localparam int BTN_CLR      = 2;
  localparam int BTN_HOLD     = 3;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// rtl/btn_event_arbiter_rr_pick.sv - combinational round-robin priority encoder (module rr_pick)
module rr_pick
  import graycode_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_idx
);

  int w_idx;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first set bit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && req[w_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - sticky button events served round-robin over valid/ready
// Optional dropped-event counter: define BTN_ARB_DROP_STAT_EN.
module btn_event_arbiter
  import graycode_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  parameter  int DCW  = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ_PULSE,
  input  logic            CMD_READY,
  output logic            CMD_VALID,
  output logic [IDW-1:0]  CMD_ID,
  output logic [NREQ-1:0] PENDING
`ifdef BTN_ARB_DROP_STAT_EN
  ,
  output logic [DCW-1:0]  DROP_CNT
`endif
);

  arb_state_t      r_state;
  logic            r_cmd_valid;
  logic [IDW-1:0]  r_cmd_id;
  logic [IDW-1:0]  r_ptr;
  logic [NREQ-1:0] r_pending;

  logic            w_load;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_pending_nxt;
  logic [NREQ-1:0] w_drop;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (r_pending),
    .ptr     (r_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  assign w_load        = (r_state == ARB_IDLE) || CMD_READY;
  assign w_clr         = (w_load && w_gnt_vld) ? (NREQ'(1) << w_gnt_idx) : '0;
  // A new pulse on the same cycle its bit is granted re-arms the flag.
  assign w_pending_nxt = (r_pending & ~w_clr) | REQ_PULSE;
  assign w_drop        = REQ_PULSE & r_pending & ~w_clr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ARB_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_ptr       <= '0;
      r_pending   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_load) begin
        if (w_gnt_vld) begin
          r_state     <= ARB_HOLD;
          r_cmd_valid <= 1'b1;
          r_cmd_id    <= w_gnt_idx;
          r_ptr       <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else begin
          r_state     <= ARB_IDLE;
          r_cmd_valid <= 1'b0;
        end
      end
    end
  end

  assign CMD_VALID = r_cmd_valid;
  assign CMD_ID    = r_cmd_id;
  assign PENDING   = r_pending;

`ifdef BTN_ARB_DROP_STAT_EN
  localparam int SW = DCW + 5;

  logic [DCW-1:0] r_drop_cnt;
  logic [4:0]     w_drop_n;
  logic [SW-1:0]  w_drop_sum;

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_drop_n = w_drop_n + 5'(w_drop[i]);
    end
  end

  assign w_drop_sum = SW'(r_drop_cnt) + SW'(w_drop_n);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum > SW'({DCW{1'b1}})) begin
      r_drop_cnt <= {DCW{1'b1}};
    end else begin
      r_drop_cnt <= w_drop_sum[DCW-1:0];
    end
  end

  assign DROP_CNT = r_drop_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = ^w_drop;
`endif

endmodule
